// File: rtl/y86_pkg.sv
//==============================================================================
// Module      : y86_pkg
// Description : Shared Y86-64 encodings: instruction codes, ALU function codes
//               and branch/move condition codes.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] I_IADDQ  = 4'hC;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_XOR = 2'd3
    } alu_fn_e;

    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    localparam logic [63:0] c_STACK_STEP = 64'd8;

endpackage

`default_nettype wire

// File: rtl/y86_alu.sv
//==============================================================================
// Module      : y86_alu
// Description : 64-bit Y86 ALU computing B op A with zero/sign/overflow flags.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module y86_alu
    import y86_pkg::*;
(
    input  logic [63:0] i_a,
    input  logic [63:0] i_b,
    input  alu_fn_e     i_fn,
    output logic [63:0] o_result,
    output logic        o_zf,
    output logic        o_sf,
    output logic        o_of
);

    logic [63:0] w_result;
    logic        w_of;

    always_comb begin
        w_result = '0;
        w_of     = 1'b0;
        case (i_fn)
            ALU_ADD: begin
                w_result = i_b + i_a;
                w_of     = (i_a[63] == i_b[63]) && (w_result[63] != i_a[63]);
            end
            ALU_SUB: begin
                w_result = i_b - i_a;
                w_of     = (i_a[63] != i_b[63]) && (w_result[63] != i_b[63]);
            end
            ALU_AND: w_result = i_b & i_a;
            ALU_XOR: w_result = i_b ^ i_a;
            default: ;
        endcase
    end

    assign o_result = w_result;
    assign o_zf     = (w_result == 64'd0);
    assign o_sf     = w_result[63];
    assign o_of     = w_of;

endmodule

`default_nettype wire

// File: rtl/seq_execute.sv
//==============================================================================
// Module      : seq_execute
// Description : Y86-64 SEQ execute stage: ALU operand select, valE mux,
//               condition-code register and cnd evaluation.
//               Build option EXEC_IADDQ_EN adds iaddq (icode C).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module seq_execute
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  icode,
    input  logic [3:0]  ifun,
    input  logic [63:0] ValA,
    input  logic [63:0] ValB,
    input  logic [63:0] ValC,
    output logic [63:0] ValE,
    output logic        cnd,
    output logic        zf,
    output logic        sf,
    output logic        of
);

    logic [63:0] w_alu_a;
    logic [63:0] w_alu_b;
    alu_fn_e     w_alu_fn;
    logic [63:0] w_alu_res;
    logic        w_alu_zf;
    logic        w_alu_sf;
    logic        w_alu_of;
    logic        w_use_alu;
    logic        w_cc_we;
    logic [63:0] w_vale;
    logic        w_cnd;

    logic        r_zf;
    logic        r_sf;
    logic        r_of;

    // Operand selection; every ALU-using instruction computes B op A.
    always_comb begin
        w_alu_a   = ValA;
        w_alu_b   = ValB;
        w_alu_fn  = ALU_ADD;
        w_use_alu = 1'b0;
        w_cc_we   = 1'b0;
        case (icode)
            I_RMMOVQ, I_MRMOVQ: begin
                w_alu_a   = ValC;
                w_use_alu = 1'b1;
            end
            I_OPQ: begin
                if (ifun[3:2] == 2'b00) begin
                    w_alu_fn  = alu_fn_e'(ifun[1:0]);
                    w_use_alu = 1'b1;
                    w_cc_we   = 1'b1;
                end
            end
            I_CALL, I_PUSHQ: begin
                w_alu_a   = c_STACK_STEP;
                w_alu_fn  = ALU_SUB;
                w_use_alu = 1'b1;
            end
            I_RET, I_POPQ: begin
                w_alu_a   = c_STACK_STEP;
                w_use_alu = 1'b1;
            end
`ifdef EXEC_IADDQ_EN
            I_IADDQ: begin
                w_alu_a   = ValC;
                w_use_alu = 1'b1;
                w_cc_we   = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    y86_alu u_alu (
        .i_a      (w_alu_a),
        .i_b      (w_alu_b),
        .i_fn     (w_alu_fn),
        .o_result (w_alu_res),
        .o_zf     (w_alu_zf),
        .o_sf     (w_alu_sf),
        .o_of     (w_alu_of)
    );

    always_comb begin
        w_vale = '0;
        if (w_use_alu) begin
            w_vale = w_alu_res;
        end else if (icode == I_RRMOVQ) begin
            w_vale = ValA;
        end else if (icode == I_IRMOVQ) begin
            w_vale = ValC;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_zf <= 1'b1;
            r_sf <= 1'b0;
            r_of <= 1'b0;
        end else if (w_cc_we) begin
            r_zf <= w_alu_zf;
            r_sf <= w_alu_sf;
            r_of <= w_alu_of;
        end
    end

    // Condition uses the CC as it stands this cycle, not the value being written.
    always_comb begin
        w_cnd = 1'b0;
        if ((icode == I_RRMOVQ) || (icode == I_JXX)) begin
            case (ifun)
                C_YES:   w_cnd = 1'b1;
                C_LE:    w_cnd = (r_sf ^ r_of) | r_zf;
                C_L:     w_cnd = r_sf ^ r_of;
                C_E:     w_cnd = r_zf;
                C_NE:    w_cnd = ~r_zf;
                C_GE:    w_cnd = ~(r_sf ^ r_of);
                C_G:     w_cnd = ~(r_sf ^ r_of) & ~r_zf;
                default: w_cnd = 1'b0;
            endcase
        end
    end

    assign ValE = w_vale;
    assign cnd  = w_cnd;
    assign zf   = r_zf;
    assign sf   = r_sf;
    assign of   = r_of;

endmodule

`default_nettype wire

// File: tb/tb_seq_execute.sv
//==============================================================================
// Module      : tb_seq_execute
// Description : Scoreboard bench for seq_execute against a reference model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_seq_execute;

    typedef struct {
        logic [63:0] vale;
        logic        cnd;
        logic        zf;
        logic        sf;
        logic        of;
    } exp_t;

    localparam logic signed [65:0] c_MAXS = 66'sd9223372036854775807;
    localparam logic signed [65:0] c_MINS = -66'sd9223372036854775808;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  icode = 4'h1;
    logic [3:0]  ifun = 4'h0;
    logic [63:0] ValA = '0;
    logic [63:0] ValB = '0;
    logic [63:0] ValC = '0;
    logic [63:0] ValE;
    logic        cnd;
    logic        zf;
    logic        sf;
    logic        of;

    exp_t q[$];
    logic chk_valid = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    logic m_zf = 1'b1;
    logic m_sf = 1'b0;
    logic m_of = 1'b0;
    logic m_known = 1'b0;

    always #5 clk = ~clk;

    seq_execute dut (
        .clk   (clk),
        .reset (reset),
        .icode (icode),
        .ifun  (ifun),
        .ValA  (ValA),
        .ValB  (ValB),
        .ValC  (ValC),
        .ValE  (ValE),
        .cnd   (cnd),
        .zf    (zf),
        .sf    (sf),
        .of    (of)
    );

    function automatic logic iaddq_on();
`ifdef EXEC_IADDQ_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [63:0] ref_vale(input logic [3:0] ic, input logic [3:0] fn,
                                             input logic [63:0] a, input logic [63:0] b,
                                             input logic [63:0] c);
        case (ic)
            4'h2: return a;
            4'h3: return c;
            4'h4, 4'h5: return b + c;
            4'h6: begin
                if (fn == 4'd0) return b + a;
                if (fn == 4'd1) return b - a;
                if (fn == 4'd2) return b & a;
                if (fn == 4'd3) return b ^ a;
                return 64'd0;
            end
            4'h8, 4'hA: return b - 64'd8;
            4'h9, 4'hB: return b + 64'd8;
            4'hC: return iaddq_on() ? b + c : 64'd0;
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic ref_cnd(input logic [3:0] ic, input logic [3:0] fn);
        logic less;
        less = (m_sf != m_of);
        if (ic != 4'h2 && ic != 4'h7) return 1'b0;
        case (fn)
            4'd0: return 1'b1;
            4'd1: return less || m_zf;
            4'd2: return less;
            4'd3: return m_zf;
            4'd4: return !m_zf;
            4'd5: return !less;
            4'd6: return !less && !m_zf;
            default: return 1'b0;
        endcase
    endfunction

    task automatic issue(input logic rst, input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        exp_t x;
        logic [63:0] e;
        logic signed [65:0] wide;
        logic is_add, is_sub, writes;
        @(posedge clk);
        #1;
        reset = rst; icode = ic; ifun = fn; ValA = a; ValB = b; ValC = c;
        e = ref_vale(ic, fn, a, b, c);
        if (m_known) begin
            x.vale = e; x.cnd = ref_cnd(ic, fn);
            x.zf = m_zf; x.sf = m_sf; x.of = m_of;
            q.push_back(x);
            chk_valid = 1'b1;
        end else begin
            chk_valid = 1'b0;
        end
        is_add = (ic == 4'h6 && fn == 4'd0) || (ic == 4'hC && iaddq_on());
        is_sub = (ic == 4'h6 && fn == 4'd1);
        writes = (ic == 4'h6 && fn <= 4'd3) || (ic == 4'hC && iaddq_on());
        if (rst) begin
            m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0; m_known = 1'b1;
        end else if (writes) begin
            m_zf = (e == 64'd0);
            m_sf = $signed(e) < 0;
            m_of = 1'b0;
            if (is_add) begin
                wide = $signed(b) + $signed((ic == 4'hC) ? c : a);
                m_of = (wide > c_MAXS) || (wide < c_MINS);
            end else if (is_sub) begin
                wide = $signed(b) - $signed(a);
                m_of = (wide > c_MAXS) || (wide < c_MINS);
            end
            m_known = 1'b1;
        end
    endtask

    function automatic void cmp(input string name, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
        end
    endfunction

    always @(negedge clk) begin
        exp_t x;
        if (chk_valid) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL scoreboard: got no entry expected one entry (t=%0t)", $time);
            end else begin
                x = q.pop_front();
                cmp("ValE", ValE, x.vale);
                cmp("cnd", {63'd0, cnd}, {63'd0, x.cnd});
                cmp("zf", {63'd0, zf}, {63'd0, x.zf});
                cmp("sf", {63'd0, sf}, {63'd0, x.sf});
                cmp("of", {63'd0, of}, {63'd0, x.of});
            end
        end
    end

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return 64'h7FFF_FFFF_FFFF_FFFF;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'(signed'($urandom_range(0, 40)) - 20);
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        issue(1'b1, 4'h1, 4'h0, 64'd0, 64'd0, 64'd0);
        issue(1'b1, 4'h1, 4'h0, 64'd0, 64'd0, 64'd0);
        issue(1'b0, 4'h6, 4'd1, 64'd91, 64'd100, 64'd0);
        issue(1'b0, 4'h6, 4'd0, -64'sd4, 64'd3, 64'd0);
        issue(1'b0, 4'h6, 4'd3, 64'd5, 64'd10, 64'd0);
        issue(1'b0, 4'h6, 4'd2, 64'd7, 64'd10, 64'd0);
        issue(1'b0, 4'h6, 4'd1, 64'd100, 64'd102, 64'd0);
        issue(1'b0, 4'h2, 4'd1, 64'd9, 64'd0, 64'd0);
        issue(1'b0, 4'h2, 4'd5, 64'd9, 64'd0, 64'd0);
        issue(1'b0, 4'h6, 4'd1, 64'd3, 64'd3, 64'd0);
        issue(1'b0, 4'h7, 4'd3, 64'd0, 64'd0, 64'd0);
        issue(1'b0, 4'h7, 4'd4, 64'd0, 64'd0, 64'd0);
        issue(1'b0, 4'h3, 4'd0, 64'd0, 64'd0, 64'd20);
        issue(1'b0, 4'h4, 4'd0, 64'd0, 64'd13, 64'd31);
        issue(1'b0, 4'h5, 4'd0, 64'd0, 64'd90, 64'd18);
        issue(1'b0, 4'h8, 4'd0, 64'd0, 64'd20, 64'd0);
        issue(1'b0, 4'h9, 4'd0, 64'd0, 64'd11, 64'd0);
        issue(1'b0, 4'hA, 4'd0, 64'd0, 64'd0, 64'd0);
        issue(1'b0, 4'hB, 4'd0, 64'd0, 64'd0, 64'd0);
        issue(1'b0, 4'h6, 4'd0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0);
        issue(1'b0, 4'h7, 4'd2, 64'd0, 64'd0, 64'd0);
        issue(1'b0, 4'hC, 4'd0, 64'd5, 64'd7, 64'h7FFF_FFFF_FFFF_FFFF);
        issue(1'b1, 4'h6, 4'd1, 64'd5, 64'd9, 64'd0);
        issue(1'b0, 4'h7, 4'd3, 64'd0, 64'd0, 64'd0);
        for (int i = 0; i < 400; i++) begin
            issue(($urandom_range(0, 31) == 0), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 7)),
                  rnd64(), rnd64(), rnd64());
        end
        issue(1'b0, 4'h1, 4'd0, 64'd0, 64'd0, 64'd0);
        @(posedge clk);
        #1;
        chk_valid = 1'b0;
        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: got %0d entries left expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
